// File: rtl/slink_stream_dechopper_if.sv
// Stream bundle for the serial-link RX dechopper: chunked input side
// (per-element valid) and reassembled-word output side (single valid).
interface slink_stream_dechopper_if #(
  parameter type element_t = logic [15:0],
  parameter int  Width     = -1
);

  element_t [Width-1:0] data_i;
  logic     [Width-1:0] valid_i;
  logic                 ready_o;
  element_t [Width-1:0] data_o;
  logic                 valid_o;
  logic                 ready_i;

  modport slave (
    input  data_i,
    input  valid_i,
    output ready_o,
    output data_o,
    output valid_o,
    input  ready_i
  );

  modport master (
    output data_i,
    output valid_i,
    input  ready_o,
    input  data_o,
    input  valid_o,
    output ready_i
  );

endinterface

// File: rtl/slink_stream_dechopper.sv
// Serial-link RX dechopper: reassembles chopped chunks into full words.
// Optional macro SLINK_DECHOPPER_RESYNC_EN drops assembly on misaligned flush.
module slink_stream_dechopper #(
  parameter type element_t = logic [15:0],
  parameter int  Width     = -1,
  localparam int Log2Width = $clog2(Width)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 bypass_en_i,
  input  logic [Log2Width-1:0] cfg_chopsize_i,
  slink_stream_dechopper_if.slave bus,
  output logic                 err_o
);

  localparam int CatW = $clog2(2 * Width);

  element_t [Width-1:0]   asm_q, asm_d;
  element_t [Width-1:0]   out_q, out_d;
  logic [Log2Width-1:0]   fill_q, fill_d;
  logic                   out_valid_q, out_valid_d;
  logic                   err_q, err_d;

  logic [Log2Width:0]     k;
  logic [Log2Width:0]     tot;
  logic [Width-1:0]       mask;
  element_t [2*Width-1:0] cat;
  logic                   thermo_ok;
  logic                   partial;
  logic                   misalign;
  logic                   ready_int;
  logic                   xfer;

  always_comb begin
    k = '0;
    for (int i = 0; i < Width; i++) begin
      k = k + {{Log2Width{1'b0}}, bus.valid_i[i]};
    end
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < Width; i++) begin
      mask[i] = (i < int'(k));
    end
  end

  // Existing fill first, then the low k elements of the new chunk.
  always_comb begin
    cat = '0;
    for (int i = 0; i < Width; i++) begin
      if (i < int'(fill_q)) cat[i] = asm_q[i];
    end
    for (int i = 0; i < Width; i++) begin
      if (i < int'(k)) cat[CatW'(int'(fill_q) + i)] = bus.data_i[i];
    end
  end

  assign thermo_ok = (mask == bus.valid_i);
  assign tot       = (Log2Width+1)'(fill_q) + k;
  assign partial   = (k != '0) && (k < {1'b0, cfg_chopsize_i});
  assign misalign  = partial && (int'(tot) != Width);

  assign ready_int = clear_i | !out_valid_q | bus.ready_i;
  assign xfer      = !bypass_en_i && !clear_i && ready_int && (k != '0);

  always_comb begin
    asm_d       = asm_q;
    fill_d      = fill_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;
    if (clear_i) begin
      asm_d       = '0;
      fill_d      = '0;
      out_d       = '0;
      out_valid_d = 1'b0;
      err_d       = 1'b0;
    end else if (!bypass_en_i) begin
      if (out_valid_q && bus.ready_i) out_valid_d = 1'b0;
      if (xfer) begin
        if (!thermo_ok || misalign) err_d = 1'b1;
`ifdef SLINK_DECHOPPER_RESYNC_EN
        if (misalign) begin
          fill_d = '0;
        end else begin
`else
        begin
`endif
          if (int'(tot) >= Width) begin
            out_d       = cat[Width-1:0];
            asm_d       = cat[2*Width-1:Width];
            out_valid_d = 1'b1;
            fill_d      = Log2Width'(int'(tot) - Width);
          end else begin
            asm_d  = cat[Width-1:0];
            fill_d = Log2Width'(tot);
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      asm_q       <= '0;
      fill_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      asm_q       <= asm_d;
      fill_q      <= fill_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign bus.ready_o = bypass_en_i ? bus.ready_i : ready_int;
  assign bus.data_o  = bypass_en_i ? bus.data_i : out_q;
  assign bus.valid_o = bypass_en_i ? |bus.valid_i : out_valid_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_slink_stream_dechopper.sv
// Bench for slink_stream_dechopper: vector table, backpressure sequence,
// randomized stream against a queue-based reference model.
module tb_slink_stream_dechopper;

  localparam int W = 8;
  localparam int CS = 3;

`ifdef SLINK_DECHOPPER_RESYNC_EN
  localparam int MisFill  = 0;
  localparam int MisFill2 = 3;
`else
  localparam int MisFill  = 4;
  localparam int MisFill2 = 7;
`endif

  typedef struct {
    bit        clr;
    bit        byp;
    logic [7:0] vld;
    bit        rdy;
    int        base;
    bit        e_ro;
    bit        e_vo;
    bit        e_err;
    int        e_fill;
    int        e_d0;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       byp;
  logic [2:0] cfg;
  logic       err;

  int checks = 0;
  int errors = 0;

  slink_stream_dechopper_if #(.element_t(logic [15:0]), .Width(W)) bus ();

  slink_stream_dechopper #(
    .element_t(logic [15:0]),
    .Width    (W)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .clear_i       (clear),
    .bypass_en_i   (byp),
    .cfg_chopsize_i(cfg),
    .bus           (bus),
    .err_o         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string n, logic [127:0] a, logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", n, a, e);
    end
  endtask

  task automatic drive(bit c, bit b, logic [7:0] v, bit r, int base);
    clear       = c;
    byp         = b;
    bus.valid_i = v;
    bus.ready_i = r;
    for (int j = 0; j < W; j++) bus.data_i[j] = 16'(base + j);
  endtask

  task automatic run_row(string n, vec_t v);
    logic [127:0] w;
    drive(v.clr, v.byp, v.vld, v.rdy, v.base);
    #3;
    chk({n, ".ready"}, 128'(bus.ready_o), 128'(v.e_ro));
    @(posedge clk);
    #1;
    chk({n, ".valid"}, 128'(bus.valid_o), 128'(v.e_vo));
    chk({n, ".err"}, 128'(err), 128'(v.e_err));
    chk({n, ".fill"}, 128'(dut.fill_q), 128'(v.e_fill));
    if (v.e_vo && v.e_d0 >= 0) begin
      for (int j = 0; j < W; j++) w[j*16 +: 16] = 16'(v.e_d0 + j);
      chk({n, ".data"}, bus.data_o, w);
    end
  endtask

  vec_t tbl[$];

  // reference model state
  logic [15:0]  pend[$];
  logic [127:0] words[$];
  bit           err_m;

  initial begin
    logic [127:0] held;
    vec_t bp;
    rst_n = 1'b0;
    cfg   = 3'(CS);
    drive(0, 0, 8'h00, 1, 0);

    // clr byp vld rdy base | ro vo err fill d0
    tbl.push_back('{0,0,8'h07,1, 0, 1,0,0,3,-1});
    tbl.push_back('{0,0,8'h07,1, 3, 1,0,0,6,-1});
    tbl.push_back('{0,0,8'h07,1, 6, 1,1,0,1, 0});
    tbl.push_back('{0,0,8'h07,1, 9, 1,0,0,4,-1});
    tbl.push_back('{0,0,8'h07,1,12, 1,0,0,7,-1});
    tbl.push_back('{0,0,8'h07,1,15, 1,1,0,2, 8});
    tbl.push_back('{0,0,8'h07,1,18, 1,0,0,5,-1});
    tbl.push_back('{0,0,8'h07,1,21, 1,1,0,0,16});
    tbl.push_back('{0,0,8'h07,1, 0, 1,0,0,3,-1});
    tbl.push_back('{0,0,8'h07,1, 3, 1,0,0,6,-1});
    tbl.push_back('{0,0,8'h03,1, 6, 1,1,0,0, 0});
    tbl.push_back('{0,0,8'h07,1, 0, 1,0,0,3,-1});
    tbl.push_back('{0,0,8'h01,1, 3, 1,0,1,MisFill,-1});
    tbl.push_back('{0,0,8'h07,1, 4, 1,0,1,MisFill2,-1});
    tbl.push_back('{1,0,8'h07,0,40, 1,0,0,0,-1});
    tbl.push_back('{0,1,8'h07,1,300, 1,1,0,0,300});
    tbl.push_back('{0,1,8'h07,0,310, 0,1,0,0,310});
    tbl.push_back('{0,1,8'h07,1,320, 1,1,0,0,320});
    tbl.push_back('{0,1,8'h00,0,330, 0,0,0,0,-1});
    tbl.push_back('{0,0,8'h2F,1, 0, 1,0,1,5,-1});
    tbl.push_back('{0,0,8'hFF,0,50, 1,1,1,5,-1});
    tbl.push_back('{0,0,8'h07,0,60, 0,1,1,5,-1});
    tbl.push_back('{1,0,8'h07,0,70, 1,0,0,0,-1});
    tbl.push_back('{0,0,8'h00,1, 0, 1,0,0,0,-1});

    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", 128'(bus.valid_o), 128'(0));
    chk("rst.data", bus.data_o, 128'(0));
    chk("rst.err", 128'(err), 128'(0));
    chk("rst.ready", 128'(bus.ready_o), 128'(1));
    rst_n = 1'b1;

    foreach (tbl[i]) run_row($sformatf("row%0d", i), tbl[i]);
    chk("clr.data", bus.data_o, 128'(0));

    // backpressure: word held for 5 cycles, then taken with new chunk
    for (int i = 0; i < 3; i++) begin
      bp = '{0,0,8'h07,1,500+3*i, 1,(i==2),0,(i==2)?1:3*(i+1),(i==2)?500:-1};
      run_row($sformatf("bp_fill%0d", i), bp);
    end
    held = bus.data_o;
    for (int c = 0; c < 5; c++) begin
      drive(0, 0, 8'h07, 0, 509);
      #3;
      chk("bp.stall_ready", 128'(bus.ready_o), 128'(0));
      @(posedge clk);
      #1;
      chk("bp.stall_data", bus.data_o, held);
      chk("bp.stall_valid", 128'(bus.valid_o), 128'(1));
    end
    bp = '{0,0,8'h07,1,509, 1,0,0,4,-1};
    run_row("bp.release", bp);
    bp = '{0,0,8'h07,1,512, 1,0,0,7,-1};
    run_row("bp.next1", bp);
    bp = '{0,0,8'h07,1,515, 1,1,0,2,508};
    run_row("bp.next2", bp);

    bp = '{1,0,8'h00,1,0, 1,0,0,0,-1};
    run_row("rnd.clear", bp);

    begin
      int   nv = 1000;
      bit   have = 0;
      int   k = 0;
      int   f;
      bit   exp_ro, acc, taken, mis;
      logic [127:0] wd;
      err_m = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
        if (!have) begin
          f = pend.size();
          if (f >= 6 && $urandom_range(0, 1) == 1) k = W - f;
          else if ($urandom_range(0, 19) == 0) k = $urandom_range(1, 2);
          else k = CS;
          have = 1;
          bus.valid_i = 8'((1 << k) - 1);
          for (int j = 0; j < W; j++)
            bus.data_i[j] = (j < k) ? 16'(nv + j) : 16'($urandom);
        end
        clear = 0;
        byp = 0;
        bus.ready_i = ($urandom_range(0, 3) != 0);
        #3;
        exp_ro = (words.size() == 0) || bus.ready_i;
        chk("rnd.ready", 128'(bus.ready_o), 128'(exp_ro));
        chk("rnd.valid", 128'(bus.valid_o), 128'(words.size() != 0));
        if (words.size() != 0) chk("rnd.data", bus.data_o, words[0]);
        acc   = exp_ro;
        taken = (words.size() != 0) && bus.ready_i;
        @(posedge clk);
        #1;
        if (taken) void'(words.pop_front());
        if (acc) begin
          mis = (k < CS) && (pend.size() + k != W);
          err_m = err_m | mis;
`ifdef SLINK_DECHOPPER_RESYNC_EN
          if (mis) pend.delete();
          else
`endif
          for (int j = 0; j < k; j++) pend.push_back(16'(nv + j));
          nv += k;
          while (pend.size() >= W) begin
            for (int j = 0; j < W; j++) wd[j*16 +: 16] = pend.pop_front();
            words.push_back(wd);
          end
          have = 0;
        end
        chk("rnd.err", 128'(err), 128'(err_m));
        chk("rnd.fill", 128'(dut.fill_q), 128'(pend.size()));
      end
    end

    // reset mid-word
    drive(0, 0, 8'h07, 1, 900);
    @(posedge clk);
    #1;
    drive(0, 0, 8'h00, 0, 0);
    rst_n = 1'b0;
    #2;
    chk("rstmid.fill", 128'(dut.fill_q), 128'(0));
    chk("rstmid.valid", 128'(bus.valid_o), 128'(0));
    chk("rstmid.ready", 128'(bus.ready_o), 128'(1));
    chk("rstmid.err", 128'(err), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/slink_stream_dechopper.md
Name: slink_stream_dechopper

Overview:
Receive-side counterpart of the TX stream chopper in the Serial Link channel allocator. Input is a stream of chunks in which only the low `cfg_chopsize_i` elements are valid, or fewer for a flushed partial chunk. The block reassembles these chunks into full `Width`-element words and sends them downstream with a single valid/ready handshake. Partial chunks mark original word boundaries; a boundary that does not align with a full word is flagged as an error.

Parameters:
- `element_t`, `logic[15:0]`: element type.
- `Width`, -1 (must be overridden, ≥2): elements per reassembled word.
- `Log2Width`, `$clog2(Width)`: localparam, width of the counter and config fields.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous reset, active-low.
- `clear_i`  in  1  synchronous clear of all state.
- `bypass_en_i`  in  1  pass-through mode.
- `cfg_chopsize_i`  in  Log2Width  chunk size in elements; legal range 1..Width-1, must match the TX side.
- `data_i`  in  element_t[Width]  input chunk, valid elements start at index 0.
- `valid_i`  in  Width  per-element valid, thermometer-coded from bit 0; all-zero means no transfer.
- `ready_o`  out  1  input accepted when `ready_o` is high and `valid_i` is nonzero.
- `data_o`  out  element_t[Width]  reassembled word.
- `valid_o`  out  1  output word valid.
- `ready_i`  in  1  downstream ready.
- `err_o`  out  1  sticky misalignment / non-thermometer error.

Behaviour:
- State:
  - assembly buffer `asm_q[Width]`
  - `fill_q` (0..Width-1)
  - output register `out_q[Width]`
  - `out_valid_q`
  - `err_q`
- Reset values: all state 0. Outputs after reset (`bypass_en_i`=0): `valid_o`=0, `data_o`=0, `err_o`=0, `ready_o`=1.
- `k` = popcount(`valid_i`). A transfer occurs when `k`>0, `ready_o`=1 and `clear_i`=0.
- `ready_o` = `bypass_en_i` ? `ready_i` : (!`out_valid_q` | `ready_i`). Once accepted, an input chunk is fully consumed in one cycle; chunks are never split across cycles.
- Concatenation: `asm_q[0..fill_q-1]` followed by `data_i[0..k-1]` forms the vector C of length `fill_q`+`k` (< 2·Width).
- On transfer with `fill_q`+`k` ≥ Width:
  - `out_q` ← C[0..Width-1], `out_valid_q` ← 1.
  - `asm_q[0..r-1]` ← C[Width..], where r = `fill_q`+`k`-Width.
  - `fill_q` ← r.
- On transfer with `fill_q`+`k` < Width: `asm_q` ← C, `fill_q` ← `fill_q`+`k`.
- Output handshake: if `valid_o` & `ready_i` and no new word is produced, `out_valid_q` ← 0. A new word may be loaded in the same cycle the old one is taken, giving zero-bubble throughput.
- Latency: the chunk that completes a word → `valid_o` on the next cycle.
- Stall: while `out_valid_q`=1 and `ready_i`=0, `ready_o`=0 and `data_o`/`valid_o` hold stable. All state holds.
- Partial chunk (0 < `k` < `cfg_chopsize_i`) is a flush marker. It must leave `fill_q`+`k` == Width exactly (new `fill_q`=0). Otherwise `err_q` ← 1 and the misaligned handling below applies.
- Non-thermometer `valid_i` (a 1 above a 0) sets `err_q`; elements are taken as the low `k` positions.
- `err_o` is sticky until `clear_i` or reset.
- `clear_i`: next cycle `fill_q`=0, `out_valid_q`=0, `err_q`=0, `asm_q`/`out_q`=0. Any input in that cycle is dropped; `ready_o` is driven 1 for that cycle. Clear has priority over a simultaneous transfer and over a simultaneous stall.
- Bypass: `data_o`=`data_i`, `valid_o`=|`valid_i`, `ready_o`=`ready_i`; internal state frozen. Switching bypass mid-word is illegal without `clear_i`.
- Reset mid-word: discards the partial word and the pending output.

Optional Feature:
- Macro `SLINK_DECHOPPER_RESYNC_EN`.
- When defined: a misaligned partial chunk discards all assembled elements (`fill_q` ← 0, no word emitted), so reassembly resynchronises at the next chunk. `err_q` is still set.
- When undefined: a misaligned partial chunk is accumulated like any other chunk and `err_q` is set. No state is discarded.

Test Plan (Width=8, `cfg_chopsize_i`=3, unless stated):
1. Full chunks: 8 full chunks carrying elements 0..23, `ready_i`=1 → 3 output words [0..7], [8..15], [16..23]; each `valid_o` one cycle after its completing chunk; `err_o`=0.
2. Flush marker: chunks {0,1,2}, {3,4,5}, partial {6,7} (`valid_i`=8'b11) → one word [0..7]; `fill_q`=0 afterwards; `err_o`=0.
3. Misalignment: chunk {0,1,2} then partial {3} → `err_o`=1.
   - Without the macro: the next chunk {4,5,6} is accumulated and `fill_q`=7.
   - With `SLINK_DECHOPPER_RESYNC_EN`: `fill_q`=0 after the partial chunk.
4. Backpressure: complete a word, hold `ready_i`=0 for 5 cycles → `ready_o`=0, `data_o` stable, no input lost. Raise `ready_i` → word taken and the next chunk accepted in the same cycle.
5. Bypass: `bypass_en_i`=1, `valid_i`=8'h07, `ready_i` toggling → `data_o`=`data_i`, `valid_o`=1, `ready_o`=`ready_i`.
6. Clear: `clear_i` pulsed with `fill_q`=5, `out_valid_q`=1 and `err_o`=1, concurrent chunk → next cycle `valid_o`=0, `err_o`=0, chunk dropped, `fill_q`=0.
